// File: rtl/p6_pkg.sv
// Shared constants for the P6 datapath: widths, operand-fetch FSM states and
// the shift codes understood by the downstream shifter.
package p6_pkg;

    localparam int DATA_W = 16;
    localparam int NREGS  = 8;
    localparam int AW     = 3;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD_A = 2'b01,
        RD_B = 2'b10,
        DONE = 2'b11
    } state_t;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

endpackage

// File: rtl/p6_operand_fetch_if.sv
// Request, write-back and operand signals between the P6 controller and the
// operand-fetch stage.
interface p6_operand_fetch_if;

    logic                         start;
    logic [p6_pkg::AW-1:0]        rn;
    logic [p6_pkg::AW-1:0]        rm;
    logic [1:0]                   shift_in;
    logic                         use_a;
    logic                         write;
    logic [p6_pkg::AW-1:0]        wnum;
    logic [p6_pkg::DATA_W-1:0]    wdata;
    logic                         busy;
    logic                         done;
    logic [p6_pkg::DATA_W-1:0]    aout;
    logic [p6_pkg::DATA_W-1:0]    bout;
    logic [1:0]                   shift_out;

    modport master (
        output start, rn, rm, shift_in, use_a, write, wnum, wdata,
        input  busy, done, aout, bout, shift_out
    );

    modport slave (
        input  start, rn, rm, shift_in, use_a, write, wnum, wdata,
        output busy, done, aout, bout, shift_out
    );

endinterface

// File: rtl/p6_regfile.sv
// General register file: one combinational read port, one synchronous write
// port. Contents survive reset; only the write is suppressed while in reset.
module p6_regfile
    import p6_pkg::*;
#(
    parameter int W = DATA_W,
    parameter int N = NREGS,
    parameter int A = AW
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [A-1:0] rnum_i,
    output logic [W-1:0] rdata_o,
    input  logic         we_i,
    input  logic [A-1:0] wnum_i,
    input  logic [W-1:0] wdata_i
);

    logic [W-1:0] mem_q [N];

    always_ff @(posedge clk) begin
        if (reset_n && we_i) begin
            mem_q[wnum_i] <= wdata_i;
        end
    end

    // A same-edge read sees the pre-write value.
    assign rdata_o = mem_q[rnum_i];

endmodule

// File: rtl/p6_operand_fetch.sv
// Operand-fetch stage: sequences register-file reads into the A and B operand
// registers and latches the shift code for the shifter.
module p6_operand_fetch
    import p6_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    p6_operand_fetch_if.slave  bus
);

    state_t              state_q, state_d;
    logic [AW-1:0]       rn_q, rn_d;
    logic [AW-1:0]       rm_q, rm_d;
    logic [1:0]          shift_q, shift_d;
    logic [DATA_W-1:0]   aout_q, aout_d;
    logic [DATA_W-1:0]   bout_q, bout_d;
    logic [AW-1:0]       rnum;
    logic [DATA_W-1:0]   rdata;

    assign rnum = (state_q == RD_A) ? rn_q : rm_q;

    p6_regfile #(
        .W (DATA_W),
        .N (NREGS),
        .A (AW)
    ) u_regfile (
        .clk     (clk),
        .reset_n (reset_n),
        .rnum_i  (rnum),
        .rdata_o (rdata),
        .we_i    (bus.write),
        .wnum_i  (bus.wnum),
        .wdata_i (bus.wdata)
    );

    always_comb begin
        state_d = state_q;
        rn_d    = rn_q;
        rm_d    = rm_q;
        shift_d = shift_q;
        aout_d  = aout_q;
        bout_d  = bout_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    rn_d    = bus.rn;
                    rm_d    = bus.rm;
                    shift_d = bus.shift_in;
                    // MOV-type ops skip the A read and present zero instead.
                    if (bus.use_a) begin
                        state_d = RD_A;
                    end else begin
                        aout_d  = '0;
                        state_d = RD_B;
                    end
                end
            end
            RD_A: begin
                aout_d  = rdata;
                state_d = RD_B;
            end
            RD_B: begin
                bout_d  = rdata;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rn_q    <= '0;
            rm_q    <= '0;
            shift_q <= SH_NONE;
            aout_q  <= '0;
            bout_q  <= '0;
        end else begin
            state_q <= state_d;
            rn_q    <= rn_d;
            rm_q    <= rm_d;
            shift_q <= shift_d;
            aout_q  <= aout_d;
            bout_q  <= bout_d;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.aout      = aout_q;
    assign bus.bout      = bout_q;
    assign bus.shift_out = shift_q;

endmodule
